// File: rtl/dds_pdat_aligner.sv
// Sample FIFO plus PDCLK-aligned release to the DDS parallel-data pins, with a programmable
// output delay, underflow sticky flag and a windowed PDCLK edge counter for clock monitoring.

module dds_pdat_fifo #(
  parameter int W_DAT = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W_DAT-1:0]       i_dat,
  input  logic                   i_pop,
  output logic [W_DAT-1:0]       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [W_DAT-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_level;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_dat;
        r_wp        <= r_wp + AW'(1);
      end
      if (i_pop) r_rp <= r_rp + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rp];
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
endmodule

module dds_pdat_aligner #(
  parameter int W_DAT   = 16,
  parameter int DEPTH   = 16,
  parameter int N_SYNC  = 2,
  parameter int MAX_DLY = 4,
  parameter int W_WIN   = 8,
  parameter int W_CNT   = 8,
  localparam int W_DLY  = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1,
  localparam int W_LVL  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_DAT-1:0] i_in_dat,
  input  logic             i_in_vld,
  output logic             o_in_rdy,
  input  logic             i_pdc,
  input  logic             i_pol,
  input  logic             i_en,
  input  logic [W_DLY-1:0] i_dly,
  input  logic             i_clr,
  output logic [W_DAT-1:0] o_pdat,
  output logic [W_LVL-1:0] o_level,
  output logic             o_unf,
  output logic [W_CNT-1:0] o_mon_cnt
);
  localparam int N_CH = (MAX_DLY > 1) ? MAX_DLY - 1 : 1;

  logic [N_SYNC-1:0] r_sync;
  logic              r_s;
  logic              r_s_d;
  logic              w_strobe;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [W_DAT-1:0]  w_head;
  logic [W_DAT-1:0]  r_stage0;
  logic [W_DAT-1:0]  r_chain [N_CH];
  logic [W_DAT-1:0]  w_tap;
  logic [W_DAT-1:0]  r_pdat;
  logic              r_unf;
  logic [W_WIN-1:0]  r_win;
  logic [W_CNT-1:0]  r_cnt;
  logic [W_CNT-1:0]  w_cnt_nxt;
  logic [W_CNT-1:0]  r_mon;

  // s is registered after the polarity flip, so strobe is one clk after the last sync stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_s    <= 1'b0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[N_SYNC-2:0], i_pdc};
      r_s    <= r_sync[N_SYNC-1] ^ i_pol;
      r_s_d  <= r_s;
    end
  end

  assign w_strobe = r_s & ~r_s_d;
  assign w_push   = i_in_vld & ~w_full;
  assign w_pop    = w_strobe & i_en & ~w_empty;
  assign o_in_rdy = ~w_full;

  dds_pdat_fifo #(
    .W_DAT (W_DAT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_dat   (i_in_dat),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage0 <= '0;
      r_unf    <= 1'b0;
    end else begin
      if (w_strobe) begin
        if (!i_en)        r_stage0 <= '0;
        else if (!w_empty) r_stage0 <= w_head;
      end
      if (w_strobe && i_en && w_empty) r_unf <= 1'b1;
      else if (i_clr)                  r_unf <= 1'b0;
    end
  end

  // Out-of-range delay selects saturate onto the last tap.
  always_comb begin
    w_tap = r_stage0;
    for (int i = 1; i < MAX_DLY; i++) begin
      if ((int'(i_dly) == i) || ((i == MAX_DLY - 1) && (int'(i_dly) > i))) w_tap = r_chain[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) r_chain[i] <= '0;
      r_pdat <= '0;
    end else begin
      r_chain[0] <= r_stage0;
      for (int i = 1; i < N_CH; i++) r_chain[i] <= r_chain[i-1];
      r_pdat <= w_tap;
    end
  end

  assign w_cnt_nxt = (w_strobe && (r_cnt != '1)) ? r_cnt + W_CNT'(1) : r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win <= '0;
      r_cnt <= '0;
      r_mon <= '0;
    end else begin
      r_win <= r_win + W_WIN'(1);
      if (r_win == '1) begin
        r_mon <= w_cnt_nxt;
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  assign o_pdat    = r_pdat;
  assign o_unf     = r_unf;
  assign o_mon_cnt = r_mon;
endmodule

// File: doc/dds_pdat_aligner.md
Name: dds_pdat_aligner

Overview:
Parametrised successor to the per-DDS parallel-data output path. It buffers playback samples in a FIFO with a ready/valid input handshake. It aligns sample release to an externally generated, asynchronous PDCLK (polarity-selectable, oversampled in the system clock), and adds a programmable output delay. It also provides an underflow sticky flag and a windowed PDCLK edge counter for clock monitoring. It sits between the playback engine and the DDS parallel-data pins.

Parameters:
W_DAT, 16, sample width.
DEPTH, 16, FIFO depth in samples; power of two, 2 or more.
N_SYNC, 2, synchroniser stages on pdc; 2 or more.
MAX_DLY, 4, number of output delay taps; dly selects 0..MAX_DLY-1.
W_WIN, 8, monitor window length is 2^W_WIN clk cycles.
W_CNT, 8, monitor counter width; saturating.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
in_dat  in  W_DAT  sample from playback
in_vld  in  1  sample valid
in_rdy  out  1  FIFO can accept; equals !full
pdc  in  1  asynchronous PDCLK from DDS
pol  in  1  1 = use falling PDCLK edge
en  in  1  transmit enable
dly  in  clog2(MAX_DLY)  output delay select
clr  in  1  clears underflow sticky
pdat  out  W_DAT  parallel data to DDS
level  out  clog2(DEPTH)+1  FIFO occupancy
unf  out  1  underflow sticky
mon_cnt  out  W_CNT  PDCLK edges counted in last complete window

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): all registers go to 0.
  - FIFO empty, level=0, in_rdy=1, pdat=0, unf=0, mon_cnt=0.
  - Synchroniser, delay chain and window counter are cleared.
- Push: write occurs when in_vld & in_rdy at a clk edge. If in_vld is high while full, nothing is written; the source holds its data.
- Sync and edge detect:
  - s = sync[N_SYNC-1] ^ pol.
  - Registered copy s_d.
  - strobe = s & ~s_d.
- Pop, on strobe:
  - en=1 and FIFO not empty: head is loaded into stage0 and popped.
  - en=1 and FIFO empty: stage0 holds its value; unf is set.
  - en=0: stage0 is loaded with 0; no pop; unf is unchanged.
- Simultaneous push and pop: both take effect; level is unchanged. Push on full with a simultaneous pop is still refused, because in_rdy is based on the current full state.
- level: +1 on push only, -1 on pop only. Range 0..DEPTH.
- unf: set has priority over clr in the same cycle. Otherwise clr drives unf to 0.
- Delay chain:
  - chain[0] <= stage0 and chain[i] <= chain[i-1], shifting every clk, independent of strobe.
  - pdat <= (dly==0) ? stage0 : chain[dly-1].
  - A dly change takes effect at the next clk edge; one sample may be skipped or repeated.
  - dly values of MAX_DLY or above select chain[MAX_DLY-2].
- Latency:
  - pdc edge first sampled into sync[0] at edge k → strobe during cycle after edge k+N_SYNC.
  - stage0 updates at edge k+N_SYNC+1.
  - pdat updates at edge k+N_SYNC+2+dly.
- Monitor:
  - Free-running window counter, 2^W_WIN cycles.
  - The edge counter increments on strobe and saturates at 2^W_CNT-1.
  - On the last cycle of the window: mon_cnt <= count, including a strobe in that same cycle. The count restarts at 0.
  - Counting is independent of en.

Test Plan:
- Reset then idle → pdat=0, level=0, in_rdy=1, unf=0. After 256 cycles, mon_cnt=0.
- Push 0x1111, 0x2222, 0x3333 with en=1, pol=0, dly=0; pdc square wave, period 8 clk → pdat steps 0x1111, 0x2222, 0x3333, each N_SYNC+2 cycles after a pdc rise. Then unf=1 and pdat holds 0x3333.
- Push 17 samples with DEPTH=16, no pdc toggling → in_rdy=0 after 16 pushes, level=16, the 17th is held until a strobe. Push and pop in the same cycle while level=8 → level stays 8.
- pol=1, dly=3 → updates follow pdc falling edges, each 3 cycles later than with dly=0.
- pdc period 8 clk, W_WIN=8 → mon_cnt=32 (±1) after the second window. en=0 → pdat goes to 0 after the next strobe, and level is unchanged.
- rst asserted mid-stream with level=5 → immediately level=0, pdat=0. unf=1 with clr in the same cycle as an underflow strobe → unf stays 1; clr alone → unf=0.
